seg_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the 8-digit seven-segment display of the egg timer.
- Drives the 3-bit select of the 8-bit 8:1 segment-pattern mux and the matching active-low digit anodes.
- Steps through enabled digits at a programmable dwell rate, with optional anti-ghosting blanking between digits.
- Sits between the timer/display-data logic and the board display pins.

---
 rtl/seg_scan_pkg.sv | 29 ++
 rtl/seg_scan_ctrl_if.sv | 25 ++
 rtl/seg_scan_next.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and helpers for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned NDIG  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    // Width of the shared dwell/blank counter: enough to hold max(div, blank_cyc) - 1.
    function automatic int unsigned cnt_width(input int unsigned div,
                                              input int unsigned blank_cyc);
        int unsigned m;
        m = (div > blank_cyc) ? div : blank_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NDIG-1:0] anode_of(input logic [SEL_W-1:0] s);
        logic [NDIG-1:0] a;
        a    = '1;
        a[s] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: control inputs from the timer logic,
// mux select and anode outputs to the board pins.
interface seg_scan_ctrl_if;
    import seg_scan_pkg::*;

    logic             en;
    logic [NDIG-1:0]  digit_mask;
    logic [SEL_W-1:0] sel;
    logic [NDIG-1:0]  an;
    logic             blank;
    logic             frame;

    // Display-data logic side.
    modport master (
        output en, digit_mask,
        input  sel, an, blank, frame
    );

    // Scan controller side.
    modport slave (
        input  en, digit_mask,
        output sel, an, blank, frame
    );

endinterface

// File: rtl/seg_scan_next.sv
// Next-digit finder: first set bit of digit_mask strictly above cur_sel, wrapping
// modulo NDIG. With cur_sel = NDIG-1 this yields the lowest set bit.
module seg_scan_next
    import seg_scan_pkg::*;
(
    input  logic [SEL_W-1:0] cur_sel,
    input  logic [NDIG-1:0]  digit_mask,
    output logic [SEL_W-1:0] nxt_sel,
    output logic             wrap,
    output logic             none
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Priority search upward from cur_sel+1; i = NDIG lands back on cur_sel itself.
    always_comb begin
        nxt_sel = cur_sel;
        idx     = '0;
        found   = 1'b0;
        for (int i = 1; i <= NDIG; i++) begin
            idx = cur_sel + SEL_W'(i);
            if (!found && digit_mask[idx]) begin
                nxt_sel = idx;
                found   = 1'b1;
            end
        end
        none = ~|digit_mask;
        wrap = (nxt_sel <= cur_sel);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexing scan controller for the 8-digit seven-segment display.
// Optional anti-ghosting gap between digits: define SEG_SCAN_BLANK_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned     CNT_W    = cnt_width(DIV, BLANK_CYC);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [NDIG-1:0]  an_q;
    logic             blank_q;
    logic             frame_q;
`ifdef SEG_SCAN_BLANK_EN
    // Advance decision taken at the end of SHOW, applied on BLANK exit.
    logic [SEL_W-1:0] pend_sel_q;
    logic             pend_wrap_q;
`endif

    logic [SEL_W-1:0] scan_from;
    logic [SEL_W-1:0] nxt_sel;
    logic             wrap;
    logic             none;

    // From IDLE search from the top index so the finder returns the lowest set bit.
    assign scan_from = (state_q == ST_IDLE) ? SEL_W'(NDIG - 1) : sel_q;

    seg_scan_next u_next (
        .cur_sel    (scan_from),
        .digit_mask (bus.digit_mask),
        .nxt_sel    (nxt_sel),
        .wrap       (wrap),
        .none       (none)
    );

    // Scan FSM with shared dwell/blank counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            an_q        <= '1;
            blank_q     <= 1'b1;
            frame_q     <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
            pend_sel_q  <= '0;
            pend_wrap_q <= 1'b0;
`endif
        end else begin
            frame_q <= 1'b0;
            if (!bus.en) begin
                // sel deliberately holds its value while dark.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                an_q    <= '1;
                blank_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!none) begin
                            state_q <= ST_SHOW;
                            cnt_q   <= '0;
                            sel_q   <= nxt_sel;
                            an_q    <= anode_of(nxt_sel);
                            blank_q <= 1'b0;
                        end
                    end
                    ST_SHOW: begin
                        if (cnt_q == DIV_LAST) begin
                            cnt_q <= '0;
                            if (none) begin
                                state_q <= ST_IDLE;
                                an_q    <= '1;
                                blank_q <= 1'b1;
                            end else begin
`ifdef SEG_SCAN_BLANK_EN
                                state_q     <= ST_BLANK;
                                an_q        <= '1;
                                blank_q     <= 1'b1;
                                pend_sel_q  <= nxt_sel;
                                pend_wrap_q <= wrap;
`else
                                sel_q   <= nxt_sel;
                                an_q    <= anode_of(nxt_sel);
                                frame_q <= wrap;
`endif
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`ifdef SEG_SCAN_BLANK_EN
                    ST_BLANK: begin
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= ST_SHOW;
                            cnt_q   <= '0;
                            sel_q   <= pend_sel_q;
                            an_q    <= anode_of(pend_sel_q);
                            blank_q <= 1'b0;
                            frame_q <= pend_wrap_q;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        an_q    <= '1;
                        blank_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.sel   = sel_q;
    assign bus.an    = an_q;
    assign bus.blank = blank_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIV=4, BLANK_CYC=2). Honours SEG_SCAN_BLANK_EN.
module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    localparam int unsigned DIV       = 4;
    localparam int unsigned BLANK_CYC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] an;
        logic       blank;
        logic       frame;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: outputs are presented every cycle; compare one record per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_tests++;
            if (bus.sel !== e.sel || bus.an !== e.an || bus.blank !== e.blank ||
                bus.frame !== e.frame) begin
                n_fail++;
                $display("FAIL scan_out #%0d: got sel=%0d an=%h blank=%b frame=%b, want sel=%0d an=%h blank=%b frame=%b",
                         n_tests, bus.sel, bus.an, bus.blank, bus.frame,
                         e.sel, e.an, e.blank, e.frame);
            end
        end
    end

    function automatic logic [7:0] lit(input int d);
        logic [7:0] a;
        a    = 8'hFF;
        a[d] = 1'b0;
        return a;
    endfunction

    // One clock: wait for the edge, then queue what the outputs must be after it.
    task automatic step(input int s, input logic [7:0] a, input logic b, input logic f);
        exp_t e;
        @(posedge clk);
        #1;
        e.sel   = 3'(s);
        e.an    = a;
        e.blank = b;
        e.frame = f;
        sb_q.push_back(e);
    endtask

    task automatic show_digit(input int d, input int n, input logic f_first);
        for (int c = 0; c < n; c++) step(d, lit(d), 1'b0, (c == 0) ? f_first : 1'b0);
    endtask

    task automatic gap(input int d);
`ifdef SEG_SCAN_BLANK_EN
        for (int c = 0; c < int'(BLANK_CYC); c++) step(d, 8'hFF, 1'b1, 1'b0);
`else
        if (d < 0) step(0, 8'hFF, 1'b1, 1'b0);
`endif
    endtask

    task automatic idle(input int d);
        step(d, 8'hFF, 1'b1, 1'b0);
    endtask

    // Hand-listed digit order; frame expected at the start of every pass after the first.
    task automatic scan(input int seq[8], input int len, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                show_digit(seq[i], DIV, (p > 0) && (i == 0));
                gap(seq[i]);
            end
        end
    endtask

    initial begin
        int seq[8];
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.digit_mask = 8'h00;

        // Reset state.
        step(0, 8'hFF, 1'b1, 1'b0);
        step(0, 8'hFF, 1'b1, 1'b0);

        // Full mask.
        rst = 1'b0;
        bus.en = 1'b1;
        bus.digit_mask = 8'hFF;
        seq = '{0, 1, 2, 3, 4, 5, 6, 7};
        scan(seq, 8, 2);
        bus.en = 1'b0;
        idle(7);

        // Sparse mask 1010_0100.
        bus.digit_mask = 8'b1010_0100;
        bus.en = 1'b1;
        seq = '{2, 5, 7, 0, 0, 0, 0, 0};
        scan(seq, 3, 2);
        bus.en = 1'b0;
        idle(7);

        // Single digit.
        bus.digit_mask = 8'h08;
        bus.en = 1'b1;
        seq = '{3, 0, 0, 0, 0, 0, 0, 0};
        scan(seq, 1, 3);
        bus.en = 1'b0;
        idle(3);

        // en dropped mid-slot of digit 5, then re-raised.
        bus.digit_mask = 8'hFF;
        bus.en = 1'b1;
        seq = '{0, 1, 2, 3, 4, 5, 6, 7};
        scan(seq, 5, 1);
        show_digit(5, 2, 1'b0);
        bus.en = 1'b0;
        idle(5);
        bus.en = 1'b1;
        show_digit(0, DIV, 1'b0);
        gap(0);
        show_digit(1, DIV, 1'b0);
        gap(1);

        // Mask cleared mid-slot of digit 2: slot completes, then dark, no frame.
        show_digit(2, 1, 1'b0);
        bus.digit_mask = 8'h00;
        show_digit(2, DIV - 1, 1'b0);
        idle(2);
        idle(2);
        idle(2);

        // Reset mid-scan (mid-gap when blanking is built in).
        bus.digit_mask = 8'hFF;
        show_digit(0, DIV, 1'b0);
        gap(0);
`ifdef SEG_SCAN_BLANK_EN
        show_digit(1, DIV, 1'b0);
        step(1, 8'hFF, 1'b1, 1'b0);
`else
        show_digit(1, 2, 1'b0);
`endif
        rst = 1'b1;
        step(0, 8'hFF, 1'b1, 1'b0);
        rst = 1'b0;
        step(0, 8'hFE, 1'b0, 1'b0);

        // Every queued expectation must have been consumed.
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
